// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the sequence detectors it feeds.
package seq_pkg;

  // Default word width, reused by the detectors and their benches.
  localparam int SEQ_WORD_W = 8;

  // Serializer FSM encoding.
  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-in, serial-out stage driving the detectors' seq_in.
// Words are accepted over valid/ready and emitted one bit per shift_en cycle.
// A new word can be accepted on the last-bit cycle, so back-to-back words are gapless.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   SER_IDLE  | no word in flight, ready for a load
//   SER_SHIFT | shreg holds the remaining bits, cnt = bits already sent
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_WORD_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             last_bit
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             at_last;
  logic             head_bit;

  assign at_last    = (cnt == CNT_LAST);
  assign head_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign seq_valid  = (state == SER_SHIFT);
  assign seq_out    = seq_valid & head_bit;
  assign last_bit   = seq_valid & at_last;
  // Ready in SHIFT only when this edge retires the final bit, which makes reloads seamless.
  assign load_ready = (state == SER_IDLE) | (at_last & shift_en);

  // FSM, shift register and bit counter advance together on each enabled edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SER_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        SER_IDLE: begin
          if (load_valid) begin
            shreg <= data_in;
            cnt   <= '0;
            state <= SER_SHIFT;
          end
        end
        SER_SHIFT: begin
          if (shift_en) begin
            if (!at_last) begin
              if (MSB_FIRST) begin
                shreg <= {shreg[WIDTH-2:0], 1'b0};
              end else begin
                shreg <= {1'b0, shreg[WIDTH-1:1]};
              end
              cnt <= cnt + CNT_W'(1);
            end else if (load_valid) begin
              shreg <= data_in;
              cnt   <= '0;
            end else begin
              state <= SER_IDLE;
            end
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule
